// File: rtl/dec_onehot_scan.sv
// -----------------------------------------------------------------------------
// dec_onehot_scan
//
// Registered N-to-2^N one-hot decoder with two modes:
//   direct : decodes an index loaded through IN/IN_VLD
//   scan   : walks the active bit from index 0 up to LAST, holding each
//            position for DIV clocks, then wraps back to 0 (display
//            digit/row select)
// EN=0 blanks the output. ACT_LOW=1 inverts OUT for low-true select lines.
//
// Parameters
//   IN_W    : index width, OUT_W = 2**IN_W (derived)
//   DIV     : dwell clocks per scan position (>= 1)
//   ACT_LOW : 0 = one-hot / blank all 0s, 1 = one-cold / blank all 1s
//
// Ports
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   EN        in   1 = decoder active, 0 = output blanked
//   MODE      in   0 = direct, 1 = scan
//   IN        in   index decoded in direct mode
//   IN_VLD    in   load strobe for IN
//   LAST      in   highest index visited in scan mode
//   OUT       out  registered one-hot (one-cold) select
//   IDX       out  index currently represented on OUT
//   WRAP      out  one-cycle pulse when the scan returns to index 0
//   DBG_STATE out  current FSM state (0 idle, 1 direct, 2 scan)
//
// Handshake: IN_VLD is a strobe with no back-pressure. The block is always
// ready, so IN is captured on every rising edge where IN_VLD=1 and the FSM is
// (or is entering) DIRECT; IN_VLD is ignored in IDLE and SCAN.
// -----------------------------------------------------------------------------
module dec_onehot_scan #(
  parameter int IN_W    = 4,
  parameter int DIV     = 1000,
  parameter bit ACT_LOW = 1'b0,
  localparam int OUT_W  = 2**IN_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             MODE,
  input  logic [IN_W-1:0]  IN,
  input  logic             IN_VLD,
  input  logic [IN_W-1:0]  LAST,
  output logic [OUT_W-1:0] OUT,
  output logic [IN_W-1:0]  IDX,
  output logic             WRAP,
  output logic [1:0]       DBG_STATE
);

  // With DIV=1 the counter degenerates to one bit that never leaves 0, so
  // every clock is an advance.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             active;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    active  = 1'b0;

    // Mode is re-evaluated on every edge; no sticky states.
    if (!EN) begin
      state_d = ST_IDLE;
    end else if (MODE) begin
      state_d = ST_SCAN;
    end else begin
      state_d = ST_DIRECT;
    end

    case (state_d)
      ST_DIRECT: begin
        active = 1'b1;
        cnt_d  = '0;
        if (IN_VLD) begin
          idx_d = IN;
        end
      end
      ST_SCAN: begin
        active = 1'b1;
        if (state_q != ST_SCAN) begin
          // Every entry into scan restarts the sweep from index 0.
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          // >= rather than == so a LAST lowered below the current index
          // still wraps at the end of the current dwell.
          if (idx_q >= LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IN_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // IDLE: blank output, hold IDX, clear the dwell counter.
        cnt_d = '0;
      end
    endcase

    out_d = (active ? (OUT_W'(1) << idx_d) : {OUT_W{1'b0}}) ^ {OUT_W{ACT_LOW}};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      out_q   <= {OUT_W{ACT_LOW}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      out_q   <= out_d;
    end
  end

  assign OUT       = out_q;
  assign IDX       = idx_q;
  assign WRAP      = wrap_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// -----------------------------------------------------------------------------
// tb_dec_onehot_scan
//
// Two instances: dut_a (IN_W=4, DIV=3, ACT_LOW=0) is driven from a table of
// per-clock records; dut_b (IN_W=4, DIV=1, ACT_LOW=1) and the asynchronous
// mid-scan reset are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_dec_onehot_scan;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam int         DIV_A    = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic        en_a = 1'b0, mode_a = 1'b0, vld_a = 1'b0;
  logic [3:0]  in_a = '0, last_a = '0;
  logic [15:0] out_a;
  logic [3:0]  idx_a;
  logic        wrap_a;
  logic [1:0]  st_a;

  dec_onehot_scan #(.IN_W(4), .DIV(DIV_A), .ACT_LOW(1'b0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en_a), .MODE(mode_a), .IN(in_a),
    .IN_VLD(vld_a), .LAST(last_a), .OUT(out_a), .IDX(idx_a), .WRAP(wrap_a),
    .DBG_STATE(st_a)
  );

  // ---------------- DUT B ----------------
  logic        en_b = 1'b0, mode_b = 1'b0, vld_b = 1'b0;
  logic [3:0]  in_b = '0, last_b = '0;
  logic [15:0] out_b;
  logic [3:0]  idx_b;
  logic        wrap_b;
  logic [1:0]  st_b;

  dec_onehot_scan #(.IN_W(4), .DIV(1), .ACT_LOW(1'b1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en_b), .MODE(mode_b), .IN(in_b),
    .IN_VLD(vld_b), .LAST(last_b), .OUT(out_b), .IDX(idx_b), .WRAP(wrap_b),
    .DBG_STATE(st_b)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        mode;
    logic [3:0]  in;
    logic        vld;
    logic [3:0]  last;
    logic [15:0] exp_out;
    logic [3:0]  exp_idx;
    logic        exp_wrap;
    logic [1:0]  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic mode, input logic [3:0] in,
                              input logic vld, input logic [3:0] last,
                              input logic [15:0] eo, input logic [3:0] ei,
                              input logic ew, input logic [1:0] es);
    vec_t v;
    v.en = en; v.mode = mode; v.in = in; v.vld = vld; v.last = last;
    v.exp_out = eo; v.exp_idx = ei; v.exp_wrap = ew; v.exp_st = es;
    return v;
  endfunction

  // Scan run of n clocks with fixed LAST, starting with the entry edge.
  // Edge e (1-based) shows position (e-1)/DIV modulo (LAST+1); WRAP is set
  // on the first clock of each return to position 0 after the entry clock.
  // IN/IN_VLD are held active to show they are ignored in scan.
  task automatic add_scan(input int last, input int n);
    int          pos;
    logic [15:0] eo;
    logic        ew;
    for (int e = 1; e <= n; e++) begin
      pos = ((e - 1) / DIV_A) % (last + 1);
      eo  = 16'h0001 << pos;
      ew  = (e > 1) && ((e - 1) % DIV_A == 0) && (pos == 0);
      vecs.push_back(mk(1'b1, 1'b1, 4'd5, 1'b1, 4'(last), eo, 4'(pos), ew, S_SCAN));
    end
  endtask

  task automatic apply_a(input vec_t v, input int k);
    logic [15:0] eo;
    @(negedge clk);
    en_a = v.en; mode_a = v.mode; in_a = v.in; vld_a = v.vld; last_a = v.last;
    exp_q.push_back(v.exp_out);
    @(posedge clk);
    #1;
    eo = exp_q.pop_front();
    chk($sformatf("a_out[%0d]", k), 32'(out_a), 32'(eo));
    chk($sformatf("a_idx[%0d]", k), 32'(idx_a), 32'(v.exp_idx));
    chk($sformatf("a_wrap[%0d]", k), 32'(wrap_a), 32'(v.exp_wrap));
    chk($sformatf("a_state[%0d]", k), 32'(st_a), 32'(v.exp_st));
  endtask

  task automatic drive_b(input logic en, input logic mode, input logic [3:0] in,
                         input logic vld, input logic [3:0] last);
    @(negedge clk);
    en_b = en; mode_b = mode; in_b = in; vld_b = vld; last_b = last;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string name, input logic [15:0] eo,
                       input logic [3:0] ei, input logic ew);
    chk({name, "_out"}, 32'(out_b), 32'(eo));
    chk({name, "_idx"}, 32'(idx_b), 32'(ei));
    chk({name, "_wrap"}, 32'(wrap_b), 32'(ew));
  endtask

  // ---------------- test ----------------
  initial begin
    // Direct: load 0xA, then hold with IN_VLD=0
    vecs.push_back(mk(1, 0, 4'hA, 1, 0, 16'h0400, 4'd10, 0, S_DIRECT));
    vecs.push_back(mk(1, 0, 4'h3, 0, 0, 16'h0400, 4'd10, 0, S_DIRECT));
    // Direct sweep of all codes
    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(1, 0, 4'(i), 1, 0, 16'h0001 << i, 4'(i), 0, S_DIRECT));
    end
    // Scan LAST=3 from DIRECT: four positions, wrap, into second lap
    add_scan(3, 16);
    // Blank: IDX holds (edge 16 showed position 1)
    vecs.push_back(mk(0, 0, 0, 0, 3, 16'h0000, 4'd1, 0, S_IDLE));
    // Scan LAST=15 up to the first clock of position 5
    add_scan(15, 16);
    // LAST lowered to 2 at IDX=5: dwell finishes, then wrap to 0
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0020, 4'd5, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0020, 4'd5, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 1, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0002, 4'd1, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0002, 4'd1, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0002, 4'd1, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0004, 4'd2, 0, S_SCAN));
    // Drop EN at IDX=2
    vecs.push_back(mk(0, 1, 0, 0, 2, 16'h0000, 4'd2, 0, S_IDLE));
    // Re-enable scan: restart at 0, advance to 1
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 1, 0, 0, 2, 16'h0002, 4'd1, 0, S_SCAN));
    // To DIRECT without IN_VLD: keeps scan index
    vecs.push_back(mk(1, 0, 4'd7, 0, 2, 16'h0002, 4'd1, 0, S_DIRECT));
    vecs.push_back(mk(1, 0, 4'd9, 1, 2, 16'h0200, 4'd9, 0, S_DIRECT));
    // SCAN -> DIRECT with IN_VLD on the switching edge
    vecs.push_back(mk(1, 1, 4'd9, 1, 2, 16'h0001, 4'd0, 0, S_SCAN));
    vecs.push_back(mk(1, 0, 4'd12, 1, 2, 16'h1000, 4'd12, 0, S_DIRECT));
    // IDLE ignores IN_VLD
    vecs.push_back(mk(0, 0, 4'd5, 1, 2, 16'h0000, 4'd12, 0, S_IDLE));
    // LAST=0: stuck at index 0, WRAP every DIV clocks
    add_scan(0, 7);
    // Full sweep with natural wrap
    vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 4'd0, 0, S_IDLE));
    add_scan(15, 49);

    // Reset: asynchronous, checked before the first clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a_out", 32'(out_a), 32'h0000);
    chk("rst_a_idx", 32'(idx_a), 32'h0);
    chk("rst_a_wrap", 32'(wrap_a), 32'h0);
    chk("rst_a_state", 32'(st_a), 32'(S_IDLE));
    chk("rst_b_out", 32'(out_b), 32'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      apply_a(vecs[k], k);
    end

    // DUT B: ACT_LOW=1, DIV=1
    drive_b(0, 0, 4'd3, 1, 0);
    chk_b("b_idle", 16'hFFFF, 4'd0, 0);
    drive_b(1, 0, 4'd0, 1, 0);
    chk_b("b_dir0", 16'hFFFE, 4'd0, 0);
    drive_b(1, 1, 4'd0, 0, 1);
    chk_b("b_scan1", 16'hFFFE, 4'd0, 0);
    drive_b(1, 1, 4'd0, 0, 1);
    chk_b("b_scan2", 16'hFFFD, 4'd1, 0);
    drive_b(1, 1, 4'd0, 0, 1);
    chk_b("b_scan3", 16'hFFFE, 4'd0, 1);
    drive_b(1, 1, 4'd0, 0, 1);
    chk_b("b_scan4", 16'hFFFD, 4'd1, 0);
    drive_b(1, 1, 4'd0, 0, 1);
    chk_b("b_scan5", 16'hFFFE, 4'd0, 1);
    drive_b(1, 1, 4'd0, 0, 0);
    chk_b("b_last0", 16'hFFFE, 4'd0, 1);
    drive_b(1, 1, 4'd0, 0, 0);
    chk_b("b_last0b", 16'hFFFE, 4'd0, 1);
    drive_b(0, 1, 4'd0, 0, 0);
    chk_b("b_blank", 16'hFFFF, 4'd0, 0);

    // Mid-scan asynchronous reset on both instances
    @(negedge clk);
    en_a = 1; mode_a = 1; vld_a = 0; last_a = 4'd3;
    en_b = 1; mode_b = 1; vld_b = 0; last_b = 4'd3;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_a_idx", 32'(idx_a), 32'h1);
    chk("pre_rst_a_out", 32'(out_a), 32'h0002);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_out", 32'(out_a), 32'h0000);
    chk("mid_rst_a_idx", 32'(idx_a), 32'h0);
    chk("mid_rst_a_wrap", 32'(wrap_a), 32'h0);
    chk("mid_rst_a_state", 32'(st_a), 32'(S_IDLE));
    chk("mid_rst_b_out", 32'(out_b), 32'hFFFF);
    chk("mid_rst_b_idx", 32'(idx_b), 32'h0);
    chk("mid_rst_b_state", 32'(st_b), 32'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_a_out", 32'(out_a), 32'h0001);
    chk("post_rst_a_state", 32'(st_a), 32'(S_SCAN));
    chk("post_rst_b_out", 32'(out_b), 32'hFFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dec_onehot_scan.md
Name: dec_onehot_scan

Overview:
Parametrised, registered N-to-2^N one-hot decoder with two operating modes.
- Direct mode: decodes a loaded index.
- Scan mode: autonomously walks the one-hot output from 0 to a programmable last index, holding each position for DIV clocks. It is used for digit/row select of LED and matrix displays.
- An enable blanks the output, and an active-level parameter supports low-true select lines.

Parameters:
IN_W, 4, index width; output width OUT_W = 2**IN_W (derived, not overridable).
DIV, 1000, dwell clocks per scan position; legal range >= 1.
ACT_LOW, 0, 0 = active output bit is 1 and inactive is all 0s; 1 = outputs inverted (active 0, inactive all 1s).

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
EN  in  1  1 = decoder active; 0 = output blanked.
MODE  in  1  0 = direct, 1 = scan.
IN  in  IN_W  index to decode in direct mode.
IN_VLD  in  1  load strobe for IN, sampled at the rising edge.
LAST  in  IN_W  highest index visited in scan mode.
OUT  out  OUT_W  registered one-hot (or one-cold) select.
IDX  out  IN_W  index currently represented on OUT.
WRAP  out  1  one-cycle pulse when the scan returns to index 0.

Behaviour:
- All outputs are registered. Decode latency is 1 clock from the sampling edge.
- Reset (RST_N=0, asynchronous, takes effect immediately):
  - state = IDLE, IDX = 0, dwell counter = 0, WRAP = 0.
  - OUT = inactive (all 0s, or all 1s if ACT_LOW).
- States: IDLE, DIRECT, SCAN. The state is evaluated every edge.
  - EN=0 -> IDLE.
  - EN=1 & MODE=0 -> DIRECT.
  - EN=1 & MODE=1 -> SCAN.
- IDLE:
  - OUT = inactive, WRAP = 0, IDX holds its value.
  - IN_VLD is ignored.
- DIRECT:
  - Each edge with IN_VLD=1: IDX <= IN, OUT <= onehot(IN).
  - IN_VLD=0: IDX and OUT hold.
  - On entry from IDLE or SCAN: OUT = onehot(IN) if IN_VLD=1 that edge, else onehot(current IDX).
  - WRAP = 0.
- SCAN entry (from IDLE or DIRECT):
  - IDX <= 0, counter <= 0, OUT <= onehot(0), WRAP <= 0.
  - IN and IN_VLD are ignored throughout scan mode.
- SCAN run:
  - The counter increments every clock.
  - When counter == DIV-1: counter <= 0 and the position advances.
  - If IDX >= LAST: IDX <= 0 and WRAP <= 1 for exactly that one cycle, coincident with OUT showing index 0.
  - Otherwise: IDX <= IDX+1, WRAP <= 0.
  - Each position is therefore held for exactly DIV clocks.
- Boundary conditions:
  - DIV=1: advances every clock; the counter is a single bit tied to 0.
  - LAST=0: OUT stays at onehot(0) and WRAP pulses every DIV clocks.
  - LAST=2**IN_W-1: full sweep, natural wrap.
  - LAST lowered mid-scan below IDX: the next advance wraps to 0 with WRAP. There is no early cut of the current dwell.
  - LAST changed mid-dwell: takes effect at the next advance compare only.
  - MODE toggled while EN=1: switches next edge; scan always restarts at 0; DIRECT keeps IDX unless IN_VLD.
  - EN deasserted mid-scan: OUT inactive next edge, counter cleared; re-enable restarts at 0.
  - Reset mid-operation: all state returns to reset values immediately, independent of CLK.
- Width rules:
  - Counter width = max(1, clog2(DIV)).
  - IDX compare is unsigned.
  - OUT always has exactly one active bit in DIRECT and SCAN, and none in IDLE.

Test Plan:
1. Reset (IN_W=4): RST_N low -> OUT=0x0000, IDX=0, WRAP=0 immediately. Assert RST_N mid-scan without CLK -> same values.
2. Direct: EN=1, MODE=0, IN=4'hA, IN_VLD=1 for one cycle -> next cycle OUT=0x0400, IDX=10. Then IN=3, IN_VLD=0 -> OUT stays 0x0400. Sweep all 16 codes -> OUT=1<<IN each time.
3. Scan (DIV=3, LAST=3): OUT = 0x0001, 0x0002, 0x0004, 0x0008, each for 3 clocks, then 0x0001 with WRAP=1 for one cycle only.
4. LAST change (DIV=3): scan with LAST=15; at IDX=5 set LAST=2 -> after the current 3-clock dwell, IDX=0, OUT=0x0001, WRAP=1.
5. Enable/mode: drop EN at IDX=2 -> OUT=0x0000, IDX=2 next cycle. Set EN=1, MODE=1 -> OUT=0x0001, IDX=0. Switch to MODE=0 with no IN_VLD -> OUT keeps the scan IDX one-hot.
6. ACT_LOW=1: IDLE -> OUT=0xFFFF. Direct IN=0, IN_VLD=1 -> OUT=0xFFFE. Scan DIV=1, LAST=1 -> OUT alternates 0xFFFE/0xFFFD, WRAP every 2nd cycle.
